// File: rtl/dcs_pkg.sv
// Shared constants, FSM encoding and the serial CRC-16 step for the Viterbi receive decoder.
package dcs_pkg;

  localparam int N_DATA  = 32;
  localparam int N_CRC   = 16;
  localparam int N_STEP  = 48;
  localparam int N_CODED = 96;

  localparam logic [15:0] CRC_POLY = 16'h8005;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // Generator taps over {u_k, u_k-1, u_k-2, u_k-3}, newest bit in the MSB.
  localparam logic [3:0] G_HI = 4'b1011;
  localparam logic [3:0] G_LO = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACS   = 3'd1,
    ST_TRACE = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // One bit of the MSB-first CRC-16 (x^16+x^15+x^2+1) shift.
  function automatic logic [15:0] crc16_step(input logic [15:0] r, input logic d);
    logic fb;
    fb = r[15] ^ d;
    crc16_step = {r[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/viterbi_acs_unit.sv
// Combinational add-compare-select for one trellis step across all 8 states.
module viterbi_acs_unit
  import dcs_pkg::*;
#(
  parameter int PM_W = 8
) (
  input  logic [7:0][PM_W-1:0] pm_in,
  input  logic [1:0]           rx_pair,
  output logic [7:0][PM_W-1:0] pm_out,
  output logic [7:0]           surv
);

  for (genvar s = 0; s < 8; s++) begin : g_state
    // Encoder window for branch b is {s, b}: s[2] is the new bit, {s[1:0], b} the predecessor.
    localparam logic [2:0] S   = 3'(s);
    localparam logic [3:0] W0  = {S, 1'b0};
    localparam logic [3:0] W1  = {S, 1'b1};
    localparam logic       E10 = ^(W0 & G_HI);
    localparam logic       E00 = ^(W0 & G_LO);
    localparam logic       E11 = ^(W1 & G_HI);
    localparam logic       E01 = ^(W1 & G_LO);

    logic [PM_W-1:0] bm0, bm1, cand0, cand1;

    assign bm0   = PM_W'(E10 ^ rx_pair[1]) + PM_W'(E00 ^ rx_pair[0]);
    assign bm1   = PM_W'(E11 ^ rx_pair[1]) + PM_W'(E01 ^ rx_pair[0]);
    assign cand0 = pm_in[{S[1:0], 1'b0}] + bm0;
    assign cand1 = pm_in[{S[1:0], 1'b1}] + bm1;
    // Strict compare so that a tie keeps the b=0 predecessor.
    assign surv[s]   = (cand1 < cand0);
    assign pm_out[s] = (cand1 < cand0) ? cand1 : cand0;
  end

endmodule

// File: rtl/viterbi_rx_decoder.sv
// Deinterleave, 8-state hard-decision Viterbi decode with traceback, and CRC-16 verification of one codeword.
module viterbi_rx_decoder
  import dcs_pkg::*;
#(
  parameter int PM_W = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [N_CODED-1:0] rx_word,
  output logic               busy,
  output logic               status,
  output logic [N_DATA-1:0]  data_out,
  output logic [N_CRC-1:0]   crc_out,
  output logic               crc_ok,
  output logic [PM_W-1:0]    pm_best
);

  localparam logic [PM_W-1:0] PM_HI = {1'b1, {(PM_W-1){1'b0}}};

  state_t                 state_r;
  logic [5:0]             step_r;
  logic [N_CODED-1:0]     fec_s;
  logic [N_CODED-1:0]     fec_r;
  logic [7:0][PM_W-1:0]   pm_r;
  logic [7:0][PM_W-1:0]   pm_next_s;
  logic [7:0]             surv_s;
  logic [7:0]             surv_r [N_STEP];
  logic [2:0]             trace_r;
  logic [15:0]            crc_r;
  logic [15:0]            crc_next_s;
  logic [PM_W-1:0]        best_pm_s;
  logic [2:0]             best_idx_s;

  // Undo the 4x4 block interleave of 6-bit groups.
  for (genvar i = 0; i < 4; i++) begin : g_di
    for (genvar j = 0; j < 4; j++) begin : g_dj
      assign fec_s[24*j + 6*i +: 6] = rx_word[(3-i)*24 + 6*j +: 6];
    end
  end

  // fec_r is shifted left each ACS step so the current pair is always at the top.
  viterbi_acs_unit #(.PM_W(PM_W)) u_acs (
    .pm_in   (pm_r),
    .rx_pair (fec_r[95:94]),
    .pm_out  (pm_next_s),
    .surv    (surv_s)
  );

  // Traceback start: lowest final metric, lowest index on a tie.
  always_comb begin
    best_pm_s  = pm_next_s[0];
    best_idx_s = 3'd0;
    for (int s = 1; s < 8; s++) begin
      if (pm_next_s[s] < best_pm_s) begin
        best_pm_s  = pm_next_s[s];
        best_idx_s = 3'(s);
      end else begin
        best_idx_s = best_idx_s;
      end
    end
  end

  // During CHECK step_r counts 0..31, so ~step_r[4:0] walks data_out MSB first.
  assign crc_next_s = crc16_step(crc_r, data_out[~step_r[4:0]]);

  // Survivor store written once per ACS step; intentionally not reset.
  always_ff @(posedge clock) begin
    if (state_r == ST_ACS) begin
      surv_r[step_r] <= surv_s;
    end
  end

  // Main sequencer: capture, 48 ACS steps, 48 traceback steps, 32 CRC steps, done.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ST_IDLE;
      step_r   <= 6'd0;
      fec_r    <= '0;
      pm_r     <= '0;
      trace_r  <= 3'd0;
      crc_r    <= CRC_INIT;
      busy     <= 1'b0;
      status   <= 1'b0;
      crc_ok   <= 1'b0;
      data_out <= 32'd0;
      crc_out  <= 16'd0;
      pm_best  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            fec_r <= fec_s;
            for (int s = 0; s < 8; s++) begin
              pm_r[s] <= (s == 0) ? '0 : PM_HI;
            end
            step_r  <= 6'd0;
            crc_r   <= CRC_INIT;
            status  <= 1'b0;
            crc_ok  <= 1'b0;
            busy    <= 1'b1;
            state_r <= ST_ACS;
          end
        end
        ST_ACS: begin
          pm_r  <= pm_next_s;
          fec_r <= {fec_r[93:0], 2'b00};
          if (step_r == 6'd47) begin
            pm_best <= best_pm_s;
            trace_r <= best_idx_s;
            state_r <= ST_TRACE;
          end else begin
            step_r <= step_r + 6'd1;
          end
        end
        ST_TRACE: begin
          // u_k lands at data_out[31-k] for k<32, else crc_out[47-k].
          if (step_r < 6'd32) begin
            data_out[~step_r[4:0]] <= trace_r[2];
          end else begin
            crc_out[~step_r[3:0]] <= trace_r[2];
          end
          trace_r <= {trace_r[1:0], surv_r[step_r][trace_r]};
          if (step_r == 6'd0) begin
            state_r <= ST_CHECK;
          end else begin
            step_r <= step_r - 6'd1;
          end
        end
        ST_CHECK: begin
          crc_r <= crc_next_s;
          if (step_r == 6'd31) begin
            crc_ok  <= (crc_next_s == crc_out);
            state_r <= ST_DONE;
          end else begin
            step_r <= step_r + 6'd1;
          end
        end
        ST_DONE: begin
          status  <= 1'b1;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
